alpha_blend: RTL and testbench
==============================

ALPHA_BLEND -- requirements
Module: alpha_blend

Interface
REQ-001 Parameter: DW, 8, pixel and atmospheric-light component width.
REQ-002 Parameter: CNT_W, 22, width of the output pixel counter.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: s_valid  input  1  upstream pixel and alpha valid.
REQ-006 Port: s_ready  output  1  block accepts the input beat this cycle.
REQ-007 Port: s_last  input  1  input beat is the final pixel of a frame.
REQ-008 Port: alpha  input  7  haze weight from alpha_calc, range 0..125 (scale 1/128).
REQ-009 Port: pix_r, pix_g, pix_b  input  DW each  hazy input pixel components.
REQ-010 Port: atm  input  DW  atmospheric light; quasi-static, sampled with every accepted beat.
REQ-011 Port: m_valid  output  1  output pixel valid.
REQ-012 Port: m_ready  input  1  downstream accepts the output beat.
REQ-013 Port: m_last  output  1  output beat is the final pixel of a frame.
REQ-014 Port: out_r, out_g, out_b  output  DW each  dehazed pixel components.
REQ-015 Port: pix_cnt  output  CNT_W  output beats transferred in the current frame.
REQ-016 Port: frame_done  output  1  one-cycle pulse after the m_last beat transfers.

Function
REQ-017 Per component c: out = clamp(pix + ((pix - atm) * alpha) >>> 7, 0, 2^DW-1).
REQ-018 pix - atm is computed as a signed (DW+1)-bit value; the product is a signed (DW+8)-bit value.
REQ-019 The shift is arithmetic; the sum is evaluated in a signed (DW+2)-bit value before clamping.
REQ-020 Values below 0 clamp to 0; values above 2^DW-1 clamp to 2^DW-1.
REQ-021 Pipeline has three register stages: S1 difference, S2 product, S3 sum/clamp.
REQ-022 Each stage carries a valid bit and a last bit.
REQ-023 Latency: the first output is valid 3 cycles after an input handshake when m_ready is held high.
REQ-024 Global advance enable: adv = m_ready | ~m_valid, where m_valid is the S3 valid bit.
REQ-025 s_ready = adv; all stages load only when adv = 1; otherwise every stage holds its value.
REQ-026 An input beat is accepted only when s_valid & s_ready; when adv = 1 and s_valid = 0, S1 valid loads 0.
REQ-027 Throughput is one pixel per cycle while m_ready = 1; no beat is dropped or duplicated under any m_ready pattern.
REQ-028 Outputs and m_last remain stable while m_valid = 1 and m_ready = 0.
REQ-029 pix_cnt increments on each m_valid & m_ready handshake.
REQ-030 On the m_last handshake, pix_cnt returns to 0 and frame_done pulses on the next cycle.
REQ-031 pix_cnt wraps modulo 2^CNT_W if m_last never arrives.
REQ-032 alpha = 0 passes pix through unchanged; pix = atm gives out = pix for any alpha.

Reset
REQ-033 While rst_n = 0: all stage valid bits, m_valid, m_last, frame_done, pix_cnt and out_* are 0.
REQ-034 Reset asserted mid-frame discards all in-flight beats; no output beat follows reset without a new input handshake.
REQ-035 s_ready reads 1 during and after reset, because m_valid = 0.

Configuration
REQ-036 With macro ALPHA_BLEND_ROUND_EN defined, 64 is added to the product before the >>> 7 (round-half-up).
REQ-037 Without ALPHA_BLEND_ROUND_EN, the shift truncates toward negative infinity; latency and interface are identical in both builds.

Verification
REQ-038 Pass-through: pix=(200,100,50), atm=180, alpha=0 -> out=(200,100,50) after 3 cycles, m_ready=1.
REQ-039 Clamp high: pix=250, atm=10, alpha=125 -> out=255; clamp low: pix=5, atm=250, alpha=125 -> out=0.
REQ-040 Rounding: pix=101, atm=100, alpha=64 -> out=101 without ALPHA_BLEND_ROUND_EN, 102 with it.
REQ-041 Backpressure: 16-beat stream with random m_ready -> 16 outputs in order with values matching the model, stable while stalled.
REQ-042 Frame: 10-beat frame with s_last on beat 10 -> pix_cnt reaches 9 and then returns to 0, frame_done pulses once, m_last only on output 10.
REQ-043 Reset: rst_n low with 2 beats in flight -> m_valid=0, pix_cnt=0, and no stale output after rst_n rises.

Source files
------------

// File: rtl/alpha_blend.sv
// alpha_blend: three-stage dehaze blend with valid/ready flow control.
//   out = clamp(pix + ((pix - atm) * alpha) >>> 7, 0, 2^DW-1) per colour component.
// Build option: define ALPHA_BLEND_ROUND_EN to add 64 to the product before the
// shift (round half-up). Without it the shift truncates toward negative infinity.
module alpha_blend #(
   parameter int DW    = 8,
   parameter int CNT_W = 22
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             s_last,
   input  logic [6:0]       alpha,
   input  logic [DW-1:0]    pix_r,
   input  logic [DW-1:0]    pix_g,
   input  logic [DW-1:0]    pix_b,
   input  logic [DW-1:0]    atm,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic [DW-1:0]    out_r,
   output logic [DW-1:0]    out_g,
   output logic [DW-1:0]    out_b,
   output logic [CNT_W-1:0] pix_cnt,
   output logic             frame_done
);
   localparam int PW = DW + 8;
   localparam int SW = DW + 2;
`ifdef ALPHA_BLEND_ROUND_EN
   localparam logic signed [PW-1:0] RND = PW'(64);
`else
   localparam logic signed [PW-1:0] RND = '0;
`endif

   logic                    adv;
   logic                    hs_out;
   logic [DW-1:0]           pix_in     [3];
   logic signed [DW:0]      s1_diff_d  [3];
   logic signed [DW:0]      s1_diff_q  [3];
   logic [DW-1:0]           s1_pix_q   [3];
   logic [6:0]              s1_alpha_q;
   logic signed [PW-1:0]    s2_prod_d  [3];
   logic signed [PW-1:0]    s2_prod_q  [3];
   logic [DW-1:0]           s2_pix_q   [3];
   logic signed [SW-1:0]    s3_shift   [3];
   logic signed [SW-1:0]    s3_sum     [3];
   logic [DW-1:0]           s3_pix_d   [3];
   logic [DW-1:0]           s3_pix_q   [3];
   logic                    s1_valid_q, s2_valid_q, s3_valid_q;
   logic                    s1_last_q,  s2_last_q,  s3_last_q;
   logic [CNT_W-1:0]        pix_cnt_d,  pix_cnt_q;
   logic                    frame_done_q;

   assign pix_in[0] = pix_r;
   assign pix_in[1] = pix_g;
   assign pix_in[2] = pix_b;

   // The whole pipe moves together; it may advance whenever the output slot is free.
   assign adv     = m_ready | ~s3_valid_q;
   assign s_ready = adv;
   assign hs_out  = s3_valid_q & m_ready;

   // S1: signed difference pix - atm.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         s1_diff_d[c] = $signed({1'b0, pix_in[c]}) - $signed({1'b0, atm});
      end
   end

   // S2: signed product of the difference with the unsigned alpha weight.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         s2_prod_d[c] = PW'(s1_diff_q[c]) * $signed(PW'(s1_alpha_q));
      end
   end

   // S3: scale by 1/128, add back to the pixel, clamp into the pixel range.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         s3_shift[c] = SW'((s2_prod_q[c] + RND) >>> 7);
         s3_sum[c]   = $signed({2'b00, s2_pix_q[c]}) + s3_shift[c];
         if (s3_sum[c][SW-1]) begin
            s3_pix_d[c] = '0;
         end else if (s3_sum[c][DW]) begin
            s3_pix_d[c] = '1;
         end else begin
            s3_pix_d[c] = s3_sum[c][DW-1:0];
         end
      end
   end

   // Pipeline registers: every stage loads on adv, otherwise all stages hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_last_q  <= 1'b0;
         s3_last_q  <= 1'b0;
         s1_alpha_q <= '0;
         for (int c = 0; c < 3; c++) begin
            s1_diff_q[c] <= '0;
            s1_pix_q[c]  <= '0;
            s2_prod_q[c] <= '0;
            s2_pix_q[c]  <= '0;
            s3_pix_q[c]  <= '0;
         end
      end else if (adv) begin
         s1_valid_q <= s_valid;
         s1_last_q  <= s_valid & s_last;
         s2_valid_q <= s1_valid_q;
         s2_last_q  <= s1_last_q;
         s3_valid_q <= s2_valid_q;
         s3_last_q  <= s2_last_q;
         s1_alpha_q <= alpha;
         for (int c = 0; c < 3; c++) begin
            s1_diff_q[c] <= s1_diff_d[c];
            s1_pix_q[c]  <= pix_in[c];
            s2_prod_q[c] <= s2_prod_d[c];
            s2_pix_q[c]  <= s1_pix_q[c];
            s3_pix_q[c]  <= s3_pix_d[c];
         end
      end
   end

   // Output beat counter: counts transfers, restarts after the frame's last beat.
   always_comb begin
      pix_cnt_d = pix_cnt_q;
      if (hs_out) begin
         pix_cnt_d = s3_last_q ? '0 : pix_cnt_q + CNT_W'(1);
      end
   end

   // Counter and end-of-frame pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         pix_cnt_q    <= pix_cnt_d;
         frame_done_q <= hs_out & s3_last_q;
      end
   end

   assign m_valid    = s3_valid_q;
   assign m_last     = s3_last_q;
   assign out_r      = s3_pix_q[0];
   assign out_g      = s3_pix_q[1];
   assign out_b      = s3_pix_q[2];
   assign pix_cnt    = pix_cnt_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_alpha_blend.sv
// Directed bench for alpha_blend: reset, latency, clamping, rounding,
// backpressure with a reference model, framing and mid-frame reset.
module tb_alpha_blend;
   localparam int DW    = 8;
   localparam int CNT_W = 22;

   logic             clk;
   logic             rst_n;
   logic             s_valid;
   logic             s_ready;
   logic             s_last;
   logic [6:0]       alpha;
   logic [DW-1:0]    pix_r, pix_g, pix_b, atm;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;
   logic [DW-1:0]    out_r, out_g, out_b;
   logic [CNT_W-1:0] pix_cnt;
   logic             frame_done;

   int n_checks = 0;
   int n_err    = 0;

   alpha_blend #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_last     (s_last),
      .alpha      (alpha),
      .pix_r      (pix_r),
      .pix_g      (pix_g),
      .pix_b      (pix_b),
      .atm        (atm),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .out_r      (out_r),
      .out_g      (out_g),
      .out_b      (out_b),
      .pix_cnt    (pix_cnt),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_beat(input int r, input int g, input int b, input int a, input int al);
      pix_r = 8'(r);
      pix_g = 8'(g);
      pix_b = 8'(b);
      atm   = 8'(a);
      alpha = 7'(al);
   endtask

   function automatic logic [7:0] model(input int p, input int a, input int al);
      int pr;
      int s;
      pr = (p - a) * al;
`ifdef ALPHA_BLEND_ROUND_EN
      pr = pr + 64;
`endif
      pr = pr >>> 7;
      s  = p + pr;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      return 8'(s);
   endfunction

   logic [23:0] exp_q[$];
   logic [23:0] exp_v;
   logic [23:0] held;
   logic        stalled;
   int          sent, got, cyc, outs, fd_cnt;
   logic        after_last;
   logic        stale;
   int          br, bg, bb, bal;

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      set_beat(0, 0, 0, 0, 0);
      repeat (3) tick();

      // Reset state
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_pix_cnt", 32'(pix_cnt), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_out_r", 32'(out_r), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Pass-through with alpha = 0, latency of three cycles
      set_beat(200, 100, 50, 180, 0);
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      tick();
      check("lat_early", 32'(m_valid), 32'd0);
      tick();
      check("pass_valid", 32'(m_valid), 32'd1);
      check("pass_r", 32'(out_r), 32'd200);
      check("pass_g", 32'(out_g), 32'd100);
      check("pass_b", 32'(out_b), 32'd50);
      tick();
      check("pass_drain", 32'(m_valid), 32'd0);
      check("pass_cnt", 32'(pix_cnt), 32'd1);

      // Clamp high/low, pix = atm, and rounding, back to back
      set_beat(250, 10, 0, 10, 125);
      s_valid = 1'b1;
      tick();
      set_beat(5, 250, 255, 250, 125);
      tick();
      set_beat(101, 100, 99, 100, 64);
      tick();
      s_valid = 1'b0;
      check("clampA_valid", 32'(m_valid), 32'd1);
      check("clampA_hi_r", 32'(out_r), 32'd255);
      check("clampA_eq_g", 32'(out_g), 32'd10);
      check("clampA_lo_b", 32'(out_b), 32'd0);
      tick();
      check("clampB_lo_r", 32'(out_r), 32'd0);
      check("clampB_eq_g", 32'(out_g), 32'd250);
      check("clampB_hi_b", 32'(out_b), 32'd255);
      tick();
`ifdef ALPHA_BLEND_ROUND_EN
      check("round_r", 32'(out_r), 32'd102);
      check("round_b", 32'(out_b), 32'd99);
`else
      check("round_r", 32'(out_r), 32'd101);
      check("round_b", 32'(out_b), 32'd98);
`endif
      check("round_eq_g", 32'(out_g), 32'd100);
      tick();

      // Backpressure: 16 beats, random m_ready and s_valid gaps
      sent    = 0;
      got     = 0;
      cyc     = 0;
      stalled = 1'b0;
      held    = '0;
      while (got < 16 && cyc < 400) begin
         if (stalled) begin
            check("bp_stall_valid", 32'(m_valid), 32'd1);
            check("bp_stall_hold", 32'({out_r, out_g, out_b}), 32'(held));
         end
         m_ready = 1'($urandom_range(0, 1));
         if (sent < 16 && $urandom_range(0, 3) != 0) begin
            br  = (sent * 16 + 5) % 256;
            bg  = 255 - sent * 13;
            bb  = (sent * 37) % 256;
            bal = sent * 8;
            set_beat(br, bg, bb, 128, bal);
            s_valid = 1'b1;
         end else begin
            s_valid = 1'b0;
         end
         #1;
         if (s_valid && s_ready) begin
            exp_q.push_back({model(br, 128, bal), model(bg, 128, bal), model(bb, 128, bal)});
            sent++;
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("bp_unexpected", 32'(m_valid), 32'd0);
            end else begin
               exp_v = exp_q.pop_front();
               check("bp_data", 32'({out_r, out_g, out_b}), 32'(exp_v));
            end
            got++;
         end
         stalled = m_valid && !m_ready;
         held    = {out_r, out_g, out_b};
         tick();
         cyc++;
      end
      check("bp_count", 32'(got), 32'd16);
      s_valid = 1'b0;
      m_ready = 1'b1;

      // Frame: 10 beats, s_last on the tenth
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      outs       = 0;
      fd_cnt     = 0;
      after_last = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i < 10) begin
            set_beat(i + 1, 0, 0, 0, 0);
            s_valid = 1'b1;
            s_last  = (i == 9);
         end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end
         #1;
         if (frame_done) fd_cnt++;
         if (after_last) begin
            check("frm_done_pulse", 32'(frame_done), 32'd1);
            check("frm_cnt_wrap", 32'(pix_cnt), 32'd0);
            after_last = 1'b0;
         end
         if (m_valid) begin
            check("frm_cnt", 32'(pix_cnt), 32'(outs));
            check("frm_last", 32'(m_last), 32'(outs == 9));
            check("frm_data", 32'(out_r), 32'(outs + 1));
            if (m_last) after_last = 1'b1;
            outs++;
         end
         tick();
      end
      check("frm_outs", 32'(outs), 32'd10);
      check("frm_done_once", 32'(fd_cnt), 32'd1);
      check("frm_cnt_end", 32'(pix_cnt), 32'd0);

      // Reset with beats in flight
      set_beat(40, 50, 60, 0, 0);
      s_valid = 1'b1;
      repeat (3) tick();
      s_valid = 1'b0;
      tick();
      check("rstf_pre_valid", 32'(m_valid), 32'd1);
      check("rstf_pre_cnt", 32'(pix_cnt), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstf_valid", 32'(m_valid), 32'd0);
      check("rstf_cnt", 32'(pix_cnt), 32'd0);
      check("rstf_out_g", 32'(out_g), 32'd0);
      check("rstf_s_ready", 32'(s_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      stale = 1'b0;
      repeat (6) begin
         tick();
         if (m_valid) stale = 1'b1;
      end
      check("rstf_no_stale", 32'(stale), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
